// File: rtl/pixel_pkg.sv
// Shared pixel/window types and FSM encoding for the 3x3 window builder.
// Included by the line buffer and the window builder top.
package pixel_pkg;

  localparam int PIX_BITS = 8;

  typedef logic [PIX_BITS-1:0] pixel_t;
  typedef pixel_t [8:0] window_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } wb_state_t;

  // A centre exists only once two full rows and two columns sit behind the new pixel.
  function automatic logic is_interior(input logic [7:0] row, input logic [7:0] col);
    return (row >= 8'd2) && (col >= 8'd2);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-tap delay line of DEPTH pixels; dout is the value shifted in DEPTH
// shifts ago, so with DEPTH = row width it yields the pixel one row above.
module line_buffer #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] taps_reg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      taps_reg <= '0;
    end else if (shift_en) begin
      taps_reg <= {taps_reg[DEPTH-2:0], din};
    end
  end

  assign dout = taps_reg[DEPTH-1];

endmodule

// File: rtl/window_builder.sv
// Raster pixel stream in, 3x3 neighbourhoods out (one per interior pixel),
// valid/ready on both sides with a single output register stage.
module window_builder #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int PIX_BITS   = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start,
  input  logic                     pix_valid,
  input  logic [PIX_BITS-1:0]      pix_in,
  output logic                     pix_ready,
  output logic                     win_valid,
  output logic [8:0][PIX_BITS-1:0] win_out,
  output logic [7:0]               win_row,
  output logic [7:0]               win_col,
  input  logic                     win_ready,
  output logic                     busy,
  output logic                     frame_done
);
  import pixel_pkg::*;

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_ACTIVE = ACTIVE;
  localparam logic [1:0] ST_DRAIN  = DRAIN;

  localparam logic [7:0] COL_LAST = 8'(IMG_WIDTH - 1);
  localparam logic [7:0] ROW_LAST = 8'(IMG_HEIGHT - 1);

  logic [1:0]                 state_reg;
  logic [7:0]                 row_reg;
  logic [7:0]                 col_reg;
  logic [8:0][PIX_BITS-1:0]   win_reg;
  logic                       win_valid_reg;
  logic [7:0]                 win_row_reg;
  logic [7:0]                 win_col_reg;
  logic                       frame_done_reg;

  logic [PIX_BITS-1:0]        tap_mid;
  logic [PIX_BITS-1:0]        tap_top;
  logic [2:0][PIX_BITS-1:0]   new_col;
  logic                       accept;
  logic                       consume;
  logic                       emit;

  // A held window blocks intake so it can never be overwritten.
  assign pix_ready = (state_reg == ST_ACTIVE) && (!win_valid_reg || win_ready);
  assign accept    = pix_valid && pix_ready;
  assign consume   = win_valid_reg && win_ready;
  assign emit      = accept && is_interior(row_reg, col_reg);

  // Index 0 = top (row r-2), 1 = middle (row r-1), 2 = bottom (current pixel).
  assign new_col = {pix_in, tap_mid, tap_top};

  line_buffer #(
    .DEPTH(IMG_WIDTH),
    .WIDTH(PIX_BITS)
  ) u_buf0 (
    .clk      (clk),
    .n_rst    (n_rst),
    .shift_en (accept),
    .din      (pix_in),
    .dout     (tap_mid)
  );

  line_buffer #(
    .DEPTH(IMG_WIDTH),
    .WIDTH(PIX_BITS)
  ) u_buf1 (
    .clk      (clk),
    .n_rst    (n_rst),
    .shift_en (accept),
    .din      (tap_mid),
    .dout     (tap_top)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg      <= ST_IDLE;
      row_reg        <= '0;
      col_reg        <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_ACTIVE;
            row_reg   <= '0;
            col_reg   <= '0;
          end
        end
        ST_ACTIVE: begin
          if (accept) begin
            if (col_reg == COL_LAST) begin
              col_reg <= '0;
              if (row_reg == ROW_LAST) begin
                row_reg   <= '0;
                state_reg <= ST_DRAIN;
              end else begin
                row_reg <= row_reg + 8'd1;
              end
            end else begin
              col_reg <= col_reg + 8'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (!win_valid_reg || win_ready) begin
            frame_done_reg <= 1'b1;
            state_reg      <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Window shifts left on every accepted pixel; the right column is the fresh tap set.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      win_reg <= '0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_reg[3*r]     <= win_reg[3*r+1];
        win_reg[3*r + 1] <= win_reg[3*r+2];
        win_reg[3*r + 2] <= new_col[r];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      win_valid_reg <= 1'b0;
      win_row_reg   <= '0;
      win_col_reg   <= '0;
    end else if (emit) begin
      win_valid_reg <= 1'b1;
      win_row_reg   <= row_reg - 8'd1;
      win_col_reg   <= col_reg - 8'd1;
    end else if (consume) begin
      win_valid_reg <= 1'b0;
    end
  end

  assign win_valid  = win_valid_reg;
  assign win_out    = win_reg;
  assign win_row    = win_row_reg;
  assign win_col    = win_col_reg;
  assign busy       = (state_reg == ST_ACTIVE) || (state_reg == ST_DRAIN);
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_window_builder.sv
// Self-checking bench for window_builder on a 4x4 frame: expected windows are
// taken directly from the image neighbourhoods of each interior centre.
module tb_window_builder;
  import pixel_pkg::*;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;
  localparam int NWIN = (W - 2) * (H - 2);

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_in = '0;
  logic       win_ready = 1'b1;
  logic       pix_ready;
  logic       win_valid;
  window_t    win_out;
  logic [7:0] win_row;
  logic [7:0] win_col;
  logic       busy;
  logic       frame_done;

  window_builder #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .PIX_BITS  (8)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .pix_valid (pix_valid),
    .pix_in    (pix_in),
    .pix_ready (pix_ready),
    .win_valid (win_valid),
    .win_out   (win_out),
    .win_row   (win_row),
    .win_col   (win_col),
    .win_ready (win_ready),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int num_cmp = 0;
  int num_err = 0;

  logic [7:0] img [N];
  window_t    obs_win [$];
  logic [7:0] obs_row [$];
  logic [7:0] obs_col [$];
  window_t    exp_win [$];
  logic [7:0] exp_row [$];
  logic [7:0] exp_col [$];

  int      first_valid_cyc, acc10_cyc, last_cons_cyc, done_cyc;
  int      busy_err, hold_err, stall_err;
  bit      timeout;
  window_t first_snap;

  int first_ref [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int last_ref  [9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
  int centre_ref [4][2] = '{'{1, 1}, '{1, 2}, '{2, 1}, '{2, 2}};

  function automatic window_t mk_win(input int v [9]);
    window_t w;
    for (int k = 0; k < 9; k++) w[k] = 8'(v[k]);
    return w;
  endfunction

  // Reference: every interior centre in raster order, window read from the image.
  task automatic build_model();
    window_t w;
    exp_win.delete(); exp_row.delete(); exp_col.delete();
    for (int r = 1; r <= H - 2; r++) begin
      for (int c = 1; c <= W - 2; c++) begin
        for (int k = 0; k < 9; k++) w[k] = img[(r - 1 + k / 3) * W + (c - 1 + k % 3)];
        exp_win.push_back(w);
        exp_row.push_back(8'(r));
        exp_col.push_back(8'(c));
      end
    end
  endtask

  function automatic int window_diffs();
    int d = 0;
    int n = (obs_win.size() < exp_win.size()) ? obs_win.size() : exp_win.size();
    for (int i = 0; i < n; i++)
      if (obs_win[i] !== exp_win[i] || obs_row[i] !== exp_row[i] || obs_col[i] !== exp_col[i]) d++;
    return d;
  endfunction

  task automatic fill_linear();
    for (int i = 0; i < N; i++) img[i] = 8'(i);
    build_model();
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
    build_model();
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    pix_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drives one frame cycle by cycle, sampling at the falling edge.
  task automatic run_frame(input bit rnd_valid, input bit rnd_ready, input int stall,
                           input bit mid_start, input int abort_at);
    int idx = 0;
    int cyc = 0;
    int stall_left = stall;
    bit pending_start = 0;
    bit start_sent = 0;
    bit abort = 0;
    obs_win.delete(); obs_row.delete(); obs_col.delete();
    first_valid_cyc = -1; acc10_cyc = -1; last_cons_cyc = -1; done_cyc = -1;
    busy_err = 0; hold_err = 0; stall_err = 0; timeout = 0;
    while (1) begin
      pix_valid = (idx < N) && (rnd_valid ? ($urandom_range(0, 1) == 1) : 1'b1);
      pix_in    = (idx < N) ? img[idx] : 8'($urandom_range(0, 255));
      if (stall > 0 && stall_left > 0) win_ready = 1'b0;
      else win_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      start = pending_start;
      pending_start = 0;
      @(negedge clk);
      cyc++;
      if (win_valid && first_valid_cyc < 0) begin
        first_valid_cyc = cyc;
        first_snap = win_out;
      end
      if (win_valid && !win_ready && pix_ready) hold_err++;
      if (stall > 0 && stall_left > 0 && win_valid) begin
        if (pix_ready || win_out !== first_snap) stall_err++;
        stall_left--;
      end
      if (!frame_done && busy !== 1'b1) busy_err++;
      if (frame_done) done_cyc = cyc;
      if (pix_valid && pix_ready) begin
        if (idx == 10) acc10_cyc = cyc;
        if (idx == 6 && mid_start && !start_sent) begin
          pending_start = 1;
          start_sent = 1;
        end
        if (idx == abort_at) abort = 1;
        idx++;
      end
      if (win_valid && win_ready) begin
        obs_win.push_back(win_out);
        obs_row.push_back(win_row);
        obs_col.push_back(win_col);
        last_cons_cyc = cyc;
        $display("window centre (%0d,%0d) data %h", win_row, win_col, win_out);
      end
      if (frame_done) break;
      if (cyc > 500) begin
        timeout = 1;
        break;
      end
      @(posedge clk); #1;
      if (abort) begin
        n_rst = 1'b0;
        break;
      end
    end
    pix_valid = 1'b0;
    start = 1'b0;
    win_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    num_cmp++;
    if ({pix_ready, win_valid, win_out, win_row, win_col, busy, frame_done} !== '0) begin
      num_err++;
      $display("FAIL reset_outputs: got %h required 0",
               {pix_ready, win_valid, win_out, win_row, win_col, busy, frame_done});
    end
    n_rst = 1'b1;
  endtask

  task automatic test_continuous();
    fill_linear();
    do_start();
    run_frame(0, 0, 0, 0, -1);
    num_cmp++;
    if (timeout !== 1'b0) begin num_err++; $display("FAIL cont_timeout: got %0d required 0", timeout); end
    num_cmp++;
    if (obs_win.size() !== NWIN) begin num_err++; $display("FAIL cont_count: got %0d required %0d", obs_win.size(), NWIN); end
    num_cmp++;
    if (window_diffs() !== 0) begin num_err++; $display("FAIL cont_windows: got %0d diffs required 0", window_diffs()); end
    num_cmp++;
    if (first_snap !== mk_win(first_ref)) begin num_err++; $display("FAIL cont_first: got %h required %h", first_snap, mk_win(first_ref)); end
    num_cmp++;
    if (obs_win.size() == 0 || obs_win[obs_win.size()-1] !== mk_win(last_ref)) begin
      num_err++; $display("FAIL cont_last: got %0d windows, last required %h", obs_win.size(), mk_win(last_ref));
    end
    for (int i = 0; i < 4; i++) begin
      num_cmp++;
      if (i >= obs_row.size() || obs_row[i] !== 8'(centre_ref[i][0]) || obs_col[i] !== 8'(centre_ref[i][1])) begin
        num_err++;
        $display("FAIL cont_centre%0d: got (%0d,%0d) required (%0d,%0d)", i,
                 (i < obs_row.size()) ? obs_row[i] : 8'hFF, (i < obs_col.size()) ? obs_col[i] : 8'hFF,
                 centre_ref[i][0], centre_ref[i][1]);
      end
    end
    num_cmp++;
    if (first_valid_cyc !== acc10_cyc + 1) begin
      num_err++; $display("FAIL cont_latency: got cycle %0d required %0d", first_valid_cyc, acc10_cyc + 1);
    end
    num_cmp++;
    if (done_cyc !== last_cons_cyc + 1) begin
      num_err++; $display("FAIL cont_done_timing: got cycle %0d required %0d", done_cyc, last_cons_cyc + 1);
    end
    num_cmp++;
    if (busy_err !== 0) begin num_err++; $display("FAIL cont_busy: got %0d low cycles required 0", busy_err); end
  endtask

  task automatic test_backpressure();
    fill_linear();
    do_start();
    run_frame(0, 0, 5, 0, -1);
    num_cmp++;
    if (stall_err !== 0) begin num_err++; $display("FAIL stall_hold: got %0d bad cycles required 0", stall_err); end
    num_cmp++;
    if (first_snap !== mk_win(first_ref)) begin num_err++; $display("FAIL stall_first: got %h required %h", first_snap, mk_win(first_ref)); end
    num_cmp++;
    if (obs_win.size() !== NWIN) begin num_err++; $display("FAIL stall_count: got %0d required %0d", obs_win.size(), NWIN); end
    num_cmp++;
    if (window_diffs() !== 0) begin num_err++; $display("FAIL stall_windows: got %0d diffs required 0", window_diffs()); end
    num_cmp++;
    if (hold_err !== 0) begin num_err++; $display("FAIL stall_ready: got %0d bad cycles required 0", hold_err); end
  endtask

  task automatic test_random_valid();
    fill_random();
    do_start();
    run_frame(1, 0, 0, 0, -1);
    num_cmp++;
    if (timeout !== 1'b0) begin num_err++; $display("FAIL rnd_timeout: got %0d required 0", timeout); end
    num_cmp++;
    if (obs_win.size() !== NWIN) begin num_err++; $display("FAIL rnd_count: got %0d required %0d", obs_win.size(), NWIN); end
    num_cmp++;
    if (window_diffs() !== 0) begin num_err++; $display("FAIL rnd_windows: got %0d diffs required 0", window_diffs()); end
    num_cmp++;
    if (busy_err !== 0) begin num_err++; $display("FAIL rnd_busy: got %0d low cycles required 0", busy_err); end
  endtask

  task automatic test_idle_ignore();
    int bad = 0;
    @(posedge clk); #1;
    pix_valid = 1'b1;
    pix_in = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pix_ready !== 1'b0 || win_valid !== 1'b0) bad++;
    end
    pix_valid = 1'b0;
    num_cmp++;
    if (bad !== 0) begin num_err++; $display("FAIL idle_ignore: got %0d active cycles required 0", bad); end
    fill_linear();
    do_start();
    run_frame(0, 0, 0, 0, -1);
    num_cmp++;
    if (obs_win.size() !== NWIN) begin num_err++; $display("FAIL idle_count: got %0d required %0d", obs_win.size(), NWIN); end
    num_cmp++;
    if (window_diffs() !== 0) begin num_err++; $display("FAIL idle_windows: got %0d diffs required 0", window_diffs()); end
  endtask

  task automatic test_mid_start();
    fill_linear();
    do_start();
    run_frame(0, 0, 0, 1, -1);
    num_cmp++;
    if (timeout !== 1'b0) begin num_err++; $display("FAIL midstart_timeout: got %0d required 0", timeout); end
    num_cmp++;
    if (obs_win.size() !== NWIN) begin num_err++; $display("FAIL midstart_count: got %0d required %0d", obs_win.size(), NWIN); end
    num_cmp++;
    if (window_diffs() !== 0) begin num_err++; $display("FAIL midstart_windows: got %0d diffs required 0", window_diffs()); end
  endtask

  task automatic test_reset_mid_frame();
    int bad = 0;
    for (int i = 0; i < N; i++) img[i] = 8'(200 - i);
    build_model();
    do_start();
    run_frame(0, 0, 0, 0, 12);
    #1;
    num_cmp++;
    if ({pix_ready, win_valid, win_out, win_row, win_col, busy, frame_done} !== '0) begin
      num_err++;
      $display("FAIL abort_outputs: got %h required 0",
               {pix_ready, win_valid, win_out, win_row, win_col, busy, frame_done});
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || busy !== 1'b0) bad++;
    end
    num_cmp++;
    if (bad !== 0) begin num_err++; $display("FAIL abort_quiet: got %0d active cycles required 0", bad); end
    fill_linear();
    do_start();
    run_frame(0, 0, 0, 0, -1);
    num_cmp++;
    if (first_snap !== mk_win(first_ref)) begin num_err++; $display("FAIL abort_first: got %h required %h", first_snap, mk_win(first_ref)); end
    num_cmp++;
    if (obs_win.size() !== NWIN) begin num_err++; $display("FAIL abort_count: got %0d required %0d", obs_win.size(), NWIN); end
    num_cmp++;
    if (window_diffs() !== 0) begin num_err++; $display("FAIL abort_windows: got %0d diffs required 0", window_diffs()); end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      fill_random();
      do_start();
      run_frame(1, 1, 0, 0, -1);
      num_cmp++;
      if (timeout !== 1'b0) begin num_err++; $display("FAIL b2b%0d_timeout: got %0d required 0", f, timeout); end
      num_cmp++;
      if (obs_win.size() !== NWIN) begin num_err++; $display("FAIL b2b%0d_count: got %0d required %0d", f, obs_win.size(), NWIN); end
      num_cmp++;
      if (window_diffs() !== 0) begin num_err++; $display("FAIL b2b%0d_windows: got %0d diffs required 0", f, window_diffs()); end
      num_cmp++;
      if (hold_err !== 0) begin num_err++; $display("FAIL b2b%0d_hold: got %0d bad cycles required 0", f, hold_err); end
      num_cmp++;
      if (done_cyc !== last_cons_cyc + 1) begin
        num_err++; $display("FAIL b2b%0d_done_timing: got cycle %0d required %0d", f, done_cyc, last_cons_cyc + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_backpressure();
    test_random_valid();
    test_idle_ignore();
    test_mid_start();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/window_builder.md
Name: window_builder

Overview:
- Sits directly downstream of the SRAM pixel-fetch/greyscale stage and upstream of the edge-detection kernel.
- Takes a raster-order stream of 8-bit greyscale pixels for one frame.
- Keeps the two previous image rows in line buffers and emits one full 3x3 neighbourhood per interior pixel, tagged with the centre coordinates.
- Valid/ready handshake on both sides; single output register stage.

Parameters:
- IMG_WIDTH, 32, pixels per row; legal range 3..256.
- IMG_HEIGHT, 32, rows per frame; legal range 3..256.
- PIX_BITS, 8, bits per greyscale pixel.

Ports:
- clk  in  1  clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame when IDLE
- pix_valid  in  1  pix_in holds a valid pixel
- pix_in  in  PIX_BITS  greyscale pixel, raster order
- pix_ready  out  1  block accepts pix_in this cycle
- win_valid  out  1  win_out holds a valid window
- win_out  out  9*PIX_BITS  packed [8:0][PIX_BITS-1:0]; index 0 = top-left, row-major, index 4 = centre, index 8 = bottom-right
- win_row  out  8  centre row of current window
- win_col  out  8  centre column of current window
- win_ready  in  1  downstream consumes window this cycle
- busy  out  1  high in ACTIVE or DRAIN
- frame_done  out  1  one-cycle pulse when the last window of the frame is consumed

Behaviour:
- Reset:
  - state = IDLE; row/col counters = 0; line buffers and window registers = 0.
  - All outputs 0: pix_ready, win_valid, win_out, win_row, win_col, busy, frame_done.
- States:
  - IDLE:
    - start=1 -> ACTIVE; row=0, col=0.
    - pix_valid is ignored; pix_ready=0.
  - ACTIVE:
    - pix_ready = !win_valid || win_ready.
    - A pixel is accepted when pix_valid && pix_ready.
    - Acceptance of pixel (IMG_HEIGHT-1, IMG_WIDTH-1) -> DRAIN.
  - DRAIN:
    - pix_ready=0.
    - Stay until the pending window (if any) is consumed: win_valid && win_ready, or win_valid already 0.
    - Then pulse frame_done for one cycle -> IDLE.
- start outside IDLE is ignored.
- On each accepted pixel p at (r,c):
  - Column taps: top = line_buf1[c] (row r-2), mid = line_buf0[c] (row r-1), bot = p.
  - The 3x3 window registers shift left one column; the new right column is {top, mid, bot}.
  - line_buf1[c] <= line_buf0[c]; line_buf0[c] <= p.
  - Implemented as circular shift registers of depth IMG_WIDTH.
  - col increments; at IMG_WIDTH-1 it wraps to 0 and row increments.
- Window emission:
  - If r>=2 && c>=2, then on the next edge: win_valid=1, win_row=r-1, win_col=c-1.
  - Latency is 1 cycle from acceptance to win_valid.
  - Windows never span the row wrap; columns 0 and 1 of each row produce no window.
- Output hold:
  - While win_valid && !win_ready, win_out/win_row/win_col hold stable and pix_ready=0 (no overwrite, no drop).
  - win_valid clears on consumption unless a new window is loaded in the same cycle; simultaneous consume + load yields a new window with win_valid staying 1.
- Counts: (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame, in raster order of centre.
- Reset mid-frame: returns immediately to reset values; the partial frame is discarded and no frame_done is issued.
- Counter widths: col/row 8 bits, compared against IMG_WIDTH-1 / IMG_HEIGHT-1.

Decomposition:
- Shared package (pixel_pkg):
  - PIX_BITS constant.
  - typedef pixel_t = logic [PIX_BITS-1:0].
  - typedef window_t = pixel_t [8:0].
  - typedef enum wb_state_t {IDLE, ACTIVE, DRAIN}.
- Sub-module line_buffer (params DEPTH, WIDTH; ports clk, n_rst, shift_en, din, dout):
  - Single-tap delay line.
  - Instantiated twice, cascaded (buf0 dout feeds buf1 din).

Test Plan:
- IMG 4x4, pixel value = linear index 0..15, win_ready=1, pix_valid continuous:
  - first win_valid one cycle after index 10 is accepted, win_out = {0,1,2,4,5,6,8,9,10}, centre (1,1).
  - exactly 4 windows total, centres (1,1),(1,2),(2,1),(2,2).
  - last window = {5,6,7,9,10,11,13,14,15}.
  - frame_done one cycle after the last window is consumed.
- Same frame, win_ready held low for 5 cycles when the first window appears:
  - pix_ready=0 throughout, win_out stable at {0,1,2,4,5,6,8,9,10}.
  - no pixel lost; total windows still 4.
- pix_valid toggled randomly with a 50% duty cycle:
  - window contents identical to the continuous case.
  - busy=1 from the cycle after start until frame_done.
- In IDLE, drive pix_valid=1 with pix_in=8'hFF for 10 cycles:
  - pix_ready=0, no win_valid.
  - A following start plus 16-pixel frame produces the normal results.
- start pulsed again mid-frame after pixel 6:
  - ignored; frame completes with 4 correct windows.
- n_rst asserted after pixel 12 accepted:
  - all outputs 0 immediately.
  - A new start plus full frame yields windows from the new data only; first window = {0,1,2,4,5,6,8,9,10}.
